// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER control path: RV32I major opcodes, control-unit states and func3 selectors.
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } cu_state_t;

    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_PRIV  = 3'b000;

endpackage

// File: rtl/otter_cu_fsm.sv
// Multicycle OTTER control unit: INIT -> FETCH -> EXEC (-> WB) (-> INTR), outputs decoded combinationally.
// Latency: one cycle per state; FETCH stalls on imem_ready, STORE-EXEC and WB stall on dmem_ready.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter bit INTR_EN   = 1'b1,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 intr,
    input  logic                 int_en,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 cu_rst,
    output logic                 mem_rden1,
    output logic                 mem_rden2,
    output logic                 mem_we2,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 csr_we,
    output logic                 int_taken,
    output logic                 mret_exec,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    cu_state_t            state_q, state_d;
    logic [INSTRET_W-1:0] instret_q;
    logic                 retire;
    logic                 skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

    assign instret = instret_q;

    always_comb begin
        state_d   = state_q;
        cu_rst    = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        illegal   = 1'b0;
        retire    = 1'b0;
        skip      = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                cu_rst  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (imem_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_STORE: begin
                        mem_we2 = 1'b1;
                        if (dmem_ready) begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        mem_rden2 = 1'b1;
                        state_d   = ST_WB;
                    end
                    OP_SYSTEM: begin
                        if (func3 == F3_CSRRW) begin
                            reg_write = 1'b1;
                            csr_we    = 1'b1;
                            pc_write  = 1'b1;
                            retire    = 1'b1;
                        end else if (func3 == F3_PRIV) begin
                            mret_exec = 1'b1;
                            pc_write  = 1'b1;
                            retire    = 1'b1;
                        end else begin
                            illegal  = 1'b1;
                            pc_write = 1'b1;
                            skip     = 1'b1;
                        end
                    end
                    default: begin
                        illegal  = 1'b1;
                        pc_write = 1'b1;
                        skip     = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                mem_rden2 = 1'b1;
                if (dmem_ready) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Interrupts are only taken at instruction boundaries (retire or illegal skip).
        if (retire || skip) begin
            state_d = (INTR_EN && intr && int_en) ? ST_INTR : ST_FETCH;
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm; a second instance (INTR_EN=0, 3-bit instret) covers interrupt masking and counter wrap.
module tb_otter_cu_fsm;

    logic clk = 1'b0;
    logic rst, intr, int_en, imem_ready, dmem_ready;
    logic [6:0] opcode;
    logic [2:0] func3;

    logic        cu_rst, mem_rden1, mem_rden2, mem_we2, pc_write;
    logic        reg_write, csr_we, int_taken, mret_exec, illegal;
    logic [31:0] instret;

    logic        b_cu_rst, b_mem_rden1, b_mem_rden2, b_mem_we2, b_pc_write;
    logic        b_reg_write, b_csr_we, b_int_taken, b_mret_exec, b_illegal;
    logic [2:0]  b_instret;

    int n_cmp = 0;
    int n_err = 0;

    // {cu_rst, mem_rden1, mem_rden2, mem_we2, pc_write, reg_write, csr_we, int_taken, mret_exec, illegal}
    logic [9:0] outs, outs_b;
    assign outs   = {cu_rst, mem_rden1, mem_rden2, mem_we2, pc_write,
                     reg_write, csr_we, int_taken, mret_exec, illegal};
    assign outs_b = {b_cu_rst, b_mem_rden1, b_mem_rden2, b_mem_we2, b_pc_write,
                     b_reg_write, b_csr_we, b_int_taken, b_mret_exec, b_illegal};

    localparam logic [9:0] O_INIT  = 10'b1000000000;
    localparam logic [9:0] O_FETCH = 10'b0100000000;
    localparam logic [9:0] O_ALU   = 10'b0000110000;
    localparam logic [9:0] O_BR    = 10'b0000100000;
    localparam logic [9:0] O_ST_W  = 10'b0001000000;
    localparam logic [9:0] O_ST_D  = 10'b0001100000;
    localparam logic [9:0] O_LD    = 10'b0010000000;
    localparam logic [9:0] O_WB_D  = 10'b0010110000;
    localparam logic [9:0] O_INTR  = 10'b0000100100;
    localparam logic [9:0] O_ILL   = 10'b0000100001;
    localparam logic [9:0] O_CSR   = 10'b0000111000;
    localparam logic [9:0] O_MRET  = 10'b0000100010;

    localparam logic [6:0] C_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP     = 7'b0110011;
    localparam logic [6:0] C_BRANCH = 7'b1100011;
    localparam logic [6:0] C_STORE  = 7'b0100011;
    localparam logic [6:0] C_LOAD   = 7'b0000011;
    localparam logic [6:0] C_SYSTEM = 7'b1110011;

    otter_cu_fsm #(.INTR_EN(1'b1), .INSTRET_W(32)) dut (
        .clk(clk), .rst(rst), .intr(intr), .int_en(int_en),
        .opcode(opcode), .func3(func3), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .cu_rst(cu_rst), .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .mem_we2(mem_we2),
        .pc_write(pc_write), .reg_write(reg_write), .csr_we(csr_we), .int_taken(int_taken),
        .mret_exec(mret_exec), .illegal(illegal), .instret(instret)
    );

    otter_cu_fsm #(.INTR_EN(1'b0), .INSTRET_W(3)) dut_b (
        .clk(clk), .rst(rst), .intr(intr), .int_en(int_en),
        .opcode(opcode), .func3(func3), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .cu_rst(b_cu_rst), .mem_rden1(b_mem_rden1), .mem_rden2(b_mem_rden2), .mem_we2(b_mem_we2),
        .pc_write(b_pc_write), .reg_write(b_reg_write), .csr_we(b_csr_we), .int_taken(b_int_taken),
        .mret_exec(b_mret_exec), .illegal(b_illegal), .instret(b_instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves both instances in INIT, just after the reset edge.
    task automatic do_reset();
        rst = 1'b1; intr = 1'b0; int_en = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        opcode = 7'd0; func3 = 3'd0;
        tick();
        rst = 1'b0;
    endtask

    // From FETCH: present an instruction word and land in EXEC.
    task automatic fetch_into(input logic [6:0] op, input logic [2:0] f3);
        imem_ready = 1'b1; opcode = op; func3 = f3;
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (outs !== O_INIT) begin n_err++; $display("FAIL reset_outs got %b exp %b", outs, O_INIT); end
        n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL reset_instret got %0d exp 0", instret); end
    endtask

    task automatic test_alu();
        do_reset(); tick();
        imem_ready = 1'b0;
        #1;
        n_cmp++; if (outs !== O_FETCH) begin n_err++; $display("FAIL fetch_stall got %b exp %b", outs, O_FETCH); end
        tick();
        fetch_into(C_IMM, 3'b000);
        #1;
        n_cmp++; if (outs !== O_ALU) begin n_err++; $display("FAIL addi_exec got %b exp %b", outs, O_ALU); end
        n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL addi_pre_instret got %0d exp 0", instret); end
        tick(); #1;
        n_cmp++; if (instret !== 32'd1) begin n_err++; $display("FAIL addi_instret got %0d exp 1", instret); end
        n_cmp++; if (outs !== O_FETCH) begin n_err++; $display("FAIL addi_next got %b exp %b", outs, O_FETCH); end
        fetch_into(C_BRANCH, 3'b000);
        #1;
        n_cmp++; if (outs !== O_BR) begin n_err++; $display("FAIL branch_exec got %b exp %b", outs, O_BR); end
        tick(); #1;
        n_cmp++; if (instret !== 32'd2) begin n_err++; $display("FAIL branch_instret got %0d exp 2", instret); end
    endtask

    task automatic test_store();
        do_reset(); tick();
        fetch_into(C_STORE, 3'b010);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (outs !== O_ST_W) begin n_err++; $display("FAIL store_wait%0d got %b exp %b", i, outs, O_ST_W); end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        n_cmp++; if (outs !== O_ST_D) begin n_err++; $display("FAIL store_done got %b exp %b", outs, O_ST_D); end
        tick();
        dmem_ready = 1'b0;
        #1;
        n_cmp++; if (instret !== 32'd1) begin n_err++; $display("FAIL store_instret got %0d exp 1", instret); end
        n_cmp++; if (outs !== O_FETCH) begin n_err++; $display("FAIL store_next got %b exp %b", outs, O_FETCH); end
    endtask

    task automatic test_load();
        do_reset(); tick();
        fetch_into(C_LOAD, 3'b010);
        dmem_ready = 1'b1;
        #1;
        n_cmp++; if (outs !== O_LD) begin n_err++; $display("FAIL load_exec got %b exp %b", outs, O_LD); end
        dmem_ready = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (outs !== O_LD) begin n_err++; $display("FAIL load_wb_wait%0d got %b exp %b", i, outs, O_LD); end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        n_cmp++; if (outs !== O_WB_D) begin n_err++; $display("FAIL load_wb_done got %b exp %b", outs, O_WB_D); end
        n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL load_pre_instret got %0d exp 0", instret); end
        tick();
        dmem_ready = 1'b0;
        #1;
        n_cmp++; if (instret !== 32'd1) begin n_err++; $display("FAIL load_instret got %0d exp 1", instret); end
        n_cmp++; if (outs !== O_FETCH) begin n_err++; $display("FAIL load_next got %b exp %b", outs, O_FETCH); end
    endtask

    task automatic test_intr();
        do_reset(); tick();
        intr = 1'b1; int_en = 1'b1;
        fetch_into(C_OP, 3'b000);
        #1;
        n_cmp++; if (outs !== O_ALU) begin n_err++; $display("FAIL intr_op_exec got %b exp %b", outs, O_ALU); end
        tick(); #1;
        n_cmp++; if (outs !== O_INTR) begin n_err++; $display("FAIL intr_entry got %b exp %b", outs, O_INTR); end
        n_cmp++; if (outs_b !== O_FETCH) begin n_err++; $display("FAIL intr_disabled_inst got %b exp %b", outs_b, O_FETCH); end
        tick(); #1;
        n_cmp++; if (outs !== O_FETCH) begin n_err++; $display("FAIL intr_exit got %b exp %b", outs, O_FETCH); end
        int_en = 1'b0;
        fetch_into(C_OP, 3'b000);
        tick(); #1;
        n_cmp++; if (outs !== O_FETCH) begin n_err++; $display("FAIL intr_masked got %b exp %b", outs, O_FETCH); end
        n_cmp++; if (instret !== 32'd2) begin n_err++; $display("FAIL intr_instret got %0d exp 2", instret); end
        intr = 1'b0;
    endtask

    task automatic test_system();
        do_reset(); tick();
        fetch_into(7'b1111111, 3'b000);
        #1;
        n_cmp++; if (outs !== O_ILL) begin n_err++; $display("FAIL illegal_exec got %b exp %b", outs, O_ILL); end
        tick(); #1;
        n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL illegal_instret got %0d exp 0", instret); end
        n_cmp++; if (outs !== O_FETCH) begin n_err++; $display("FAIL illegal_next got %b exp %b", outs, O_FETCH); end
        fetch_into(C_SYSTEM, 3'b010);
        #1;
        n_cmp++; if (outs !== O_ILL) begin n_err++; $display("FAIL sys_illegal got %b exp %b", outs, O_ILL); end
        tick();
        fetch_into(C_SYSTEM, 3'b001);
        #1;
        n_cmp++; if (outs !== O_CSR) begin n_err++; $display("FAIL csrrw_exec got %b exp %b", outs, O_CSR); end
        tick();
        fetch_into(C_SYSTEM, 3'b000);
        #1;
        n_cmp++; if (outs !== O_MRET) begin n_err++; $display("FAIL mret_exec got %b exp %b", outs, O_MRET); end
        tick(); #1;
        n_cmp++; if (instret !== 32'd2) begin n_err++; $display("FAIL system_instret got %0d exp 2", instret); end
    endtask

    task automatic test_rst_store();
        do_reset(); tick();
        fetch_into(C_IMM, 3'b000);
        tick();
        fetch_into(C_STORE, 3'b010);
        dmem_ready = 1'b0;
        #1;
        n_cmp++; if (outs !== O_ST_W) begin n_err++; $display("FAIL rst_store_wait got %b exp %b", outs, O_ST_W); end
        n_cmp++; if (instret !== 32'd1) begin n_err++; $display("FAIL rst_store_pre got %0d exp 1", instret); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (outs !== O_INIT) begin n_err++; $display("FAIL rst_store_init got %b exp %b", outs, O_INIT); end
        n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL rst_store_instret got %0d exp 0", instret); end
    endtask

    task automatic test_back_to_back();
        do_reset(); tick();
        for (int i = 1; i <= 8; i++) begin
            fetch_into(C_IMM, 3'b000);
            tick();
        end
        #1;
        n_cmp++; if (instret !== 32'd8) begin n_err++; $display("FAIL b2b_instret got %0d exp 8", instret); end
        n_cmp++; if (b_instret !== 3'd0) begin n_err++; $display("FAIL wrap_instret got %0d exp 0", b_instret); end
        fetch_into(C_IMM, 3'b000);
        tick(); #1;
        n_cmp++; if (b_instret !== 3'd1) begin n_err++; $display("FAIL wrap_after got %0d exp 1", b_instret); end
    endtask

    initial begin
        rst = 1'b1; intr = 1'b0; int_en = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        opcode = 7'd0; func3 = 3'd0;
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_intr();
        test_system();
        test_rst_store();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
